// File: rtl/pca_i2c_pkg.sv
// Shared constants for the PCA9685-compatible I2C target front end.
package pca_i2c_pkg;
   localparam int I2C_SYNC_STAGES    = 2;
   localparam int I2C_FILTER_CYCLES  = 3;
   localparam int I2C_TIMEOUT_CYCLES = 1000000;
   localparam int I2C_FILT_CNT_W     = 4;
   localparam int I2C_TIMEOUT_CNT_W  = 20;
endpackage

// File: rtl/i2c_glitch_filter.sv
// One I2C line: metastability synchroniser followed by a stable-count spike filter.
module i2c_glitch_filter
   import pca_i2c_pkg::*;
#(
   parameter int SYNC_STAGES   = I2C_SYNC_STAGES,
   parameter int FILTER_CYCLES = I2C_FILTER_CYCLES
) (
   input  logic clk_i,
   input  logic rst_ni,
   input  logic line_i,
   output logic line_o,
   output logic line_next_o
);

   localparam logic [I2C_FILT_CNT_W-1:0] CNT_LAST = I2C_FILT_CNT_W'(FILTER_CYCLES - 1);

   logic [SYNC_STAGES-1:0]    sync_q;
   logic                      synced;
   logic [I2C_FILT_CNT_W-1:0] cnt_q;
   logic [I2C_FILT_CNT_W-1:0] cnt_next;

   assign synced = sync_q[SYNC_STAGES-1];

   // line_next_o is exported so the parent can register strobes in the same
   // cycle the filtered level changes.
   always_comb begin
      line_next_o = line_o;
      cnt_next    = '0;
      if (synced != line_o) begin
         if (cnt_q == CNT_LAST) begin
            line_next_o = synced;
         end else begin
            cnt_next = cnt_q + 1'b1;
         end
      end
   end

   always_ff @(posedge clk_i or negedge rst_ni) begin
      if (!rst_ni) begin
         sync_q <= '1;
         line_o <= 1'b1;
         cnt_q  <= '0;
      end else begin
         sync_q <= {sync_q[SYNC_STAGES-2:0], line_i};
         line_o <= line_next_o;
         cnt_q  <= cnt_next;
      end
   end

endmodule

// File: rtl/i2c_line_conditioner.sv
// Filtered SCL/SDA levels, SCL edge strobes, START/STOP strobes and bus-busy flag.
// Optional SCL-low bus timeout is built only when I2C_TIMEOUT_EN is defined.
module i2c_line_conditioner
   import pca_i2c_pkg::*;
#(
   parameter int SYNC_STAGES    = I2C_SYNC_STAGES,
   parameter int FILTER_CYCLES  = I2C_FILTER_CYCLES,
   parameter int TIMEOUT_CYCLES = I2C_TIMEOUT_CYCLES
) (
   input  logic clk_i,
   input  logic rst_ni,
   input  logic scl_i,
   input  logic sda_i,
   output logic scl_o,
   output logic sda_o,
   output logic scl_rise_o,
   output logic scl_fall_o,
   output logic start_o,
   output logic stop_o,
   output logic busy_o,
   output logic timeout_o
);

   if (SYNC_STAGES < 2 || SYNC_STAGES > 4 || FILTER_CYCLES < 1 || FILTER_CYCLES > 15 ||
       TIMEOUT_CYCLES < 2 || TIMEOUT_CYCLES > 1048575) begin : g_bad_params
      $error("i2c_line_conditioner: parameter out of range");
   end

   logic scl_next;
   logic sda_next;
   logic scl_held_high;

   i2c_glitch_filter #(
      .SYNC_STAGES   (SYNC_STAGES),
      .FILTER_CYCLES (FILTER_CYCLES)
   ) u_scl_filter (
      .clk_i       (clk_i),
      .rst_ni      (rst_ni),
      .line_i      (scl_i),
      .line_o      (scl_o),
      .line_next_o (scl_next)
   );

   i2c_glitch_filter #(
      .SYNC_STAGES   (SYNC_STAGES),
      .FILTER_CYCLES (FILTER_CYCLES)
   ) u_sda_filter (
      .clk_i       (clk_i),
      .rst_ni      (rst_ni),
      .line_i      (sda_i),
      .line_o      (sda_o),
      .line_next_o (sda_next)
   );

   // A simultaneous SCL/SDA change fails this term, so it yields only an edge strobe.
   assign scl_held_high = scl_o & scl_next;

   always_ff @(posedge clk_i or negedge rst_ni) begin
      if (!rst_ni) begin
         scl_rise_o <= 1'b0;
         scl_fall_o <= 1'b0;
         start_o    <= 1'b0;
         stop_o     <= 1'b0;
      end else begin
         scl_rise_o <= ~scl_o & scl_next;
         scl_fall_o <= scl_o & ~scl_next;
         start_o    <= scl_held_high & sda_o & ~sda_next;
         stop_o     <= scl_held_high & ~sda_o & sda_next;
      end
   end

`ifdef I2C_TIMEOUT_EN
   localparam logic [I2C_TIMEOUT_CNT_W-1:0] TO_LAST = I2C_TIMEOUT_CNT_W'(TIMEOUT_CYCLES - 1);

   logic [I2C_TIMEOUT_CNT_W-1:0] to_cnt_q;
   logic                         to_hold_q;
   logic                         to_hit;

   assign to_hit = ~scl_o & busy_o & ~to_hold_q & (to_cnt_q == TO_LAST);

   // After firing, the counter parks until SCL goes high so it cannot re-fire.
   always_ff @(posedge clk_i or negedge rst_ni) begin
      if (!rst_ni) begin
         to_cnt_q  <= '0;
         to_hold_q <= 1'b0;
         timeout_o <= 1'b0;
         busy_o    <= 1'b0;
      end else begin
         timeout_o <= to_hit;
         if (scl_o) begin
            to_cnt_q  <= '0;
            to_hold_q <= 1'b0;
         end else if (to_hit) begin
            to_cnt_q  <= '0;
            to_hold_q <= 1'b1;
         end else if (busy_o && !to_hold_q) begin
            to_cnt_q <= to_cnt_q + 1'b1;
         end
         if (start_o) begin
            busy_o <= 1'b1;
         end else if (stop_o || to_hit) begin
            busy_o <= 1'b0;
         end
      end
   end
`else
   assign timeout_o = 1'b0;

   always_ff @(posedge clk_i or negedge rst_ni) begin
      if (!rst_ni) begin
         busy_o <= 1'b0;
      end else if (start_o) begin
         busy_o <= 1'b1;
      end else if (stop_o) begin
         busy_o <= 1'b0;
      end
   end
`endif

endmodule

// File: tb/tb_i2c_line_conditioner.sv
// Directed bench for i2c_line_conditioner: vector table plus hand sequences for latency, glitches, byte, reset.
module tb_i2c_line_conditioner;

   logic clk = 1'b0;
   logic rst_n;
   logic scl, sda;
   logic scl_o, sda_o, scl_rise_o, scl_fall_o, start_o, stop_o, busy_o, timeout_o;

   always #5 clk = ~clk;

   i2c_line_conditioner #(
      .TIMEOUT_CYCLES (50)
   ) dut (
      .clk_i      (clk),
      .rst_ni     (rst_n),
      .scl_i      (scl),
      .sda_i      (sda),
      .scl_o      (scl_o),
      .sda_o      (sda_o),
      .scl_rise_o (scl_rise_o),
      .scl_fall_o (scl_fall_o),
      .start_o    (start_o),
      .stop_o     (stop_o),
      .busy_o     (busy_o),
      .timeout_o  (timeout_o)
   );

   int n_checks = 0;
   int n_pass   = 0;

   int n_rise = 0, n_fall = 0, n_start = 0, n_stop = 0, n_to = 0, n_consec = 0;
   logic p_rise = 0, p_fall = 0, p_start = 0, p_stop = 0;

   always @(negedge clk) begin
      n_rise  += int'(scl_rise_o);
      n_fall  += int'(scl_fall_o);
      n_start += int'(start_o);
      n_stop  += int'(stop_o);
      n_to    += int'(timeout_o);
      if ((scl_rise_o && p_rise) || (scl_fall_o && p_fall) ||
          (start_o && p_start) || (stop_o && p_stop))
         n_consec++;
      p_rise  = scl_rise_o;
      p_fall  = scl_fall_o;
      p_start = start_o;
      p_stop  = stop_o;
   end

   task automatic chk(input string name, input int act, input int exp);
      n_checks++;
      if (act == exp) n_pass++;
      else $display("FAIL %s: got %0d, expected %0d", name, act, exp);
   endtask

   task automatic step(input int n);
      repeat (n) @(posedge clk);
      #1;
   endtask

   typedef struct {
      logic scl;
      logic sda;
      int   hold;
      logic exp_scl;
      logic exp_sda;
      logic exp_busy;
      int   d_rise;
      int   d_fall;
      int   d_start;
      int   d_stop;
   } vec_t;

   vec_t vecs[15];

   initial begin
      int b_rise, b_fall, b_start, b_stop, b_to, k, low_cycles;
      logic [8:0] pattern;

      // idle, START, byte edges, repeated START, STOP, simultaneous edges, STOP while idle
      vecs[0]  = '{1'b1, 1'b1, 100, 1'b1, 1'b1, 1'b0, 0, 0, 0, 0};
      vecs[1]  = '{1'b1, 1'b0, 10,  1'b1, 1'b0, 1'b1, 0, 0, 1, 0};
      vecs[2]  = '{1'b0, 1'b0, 10,  1'b0, 1'b0, 1'b1, 0, 1, 0, 0};
      vecs[3]  = '{1'b0, 1'b1, 10,  1'b0, 1'b1, 1'b1, 0, 0, 0, 0};
      vecs[4]  = '{1'b1, 1'b1, 10,  1'b1, 1'b1, 1'b1, 1, 0, 0, 0};
      vecs[5]  = '{1'b1, 1'b0, 10,  1'b1, 1'b0, 1'b1, 0, 0, 1, 0};
      vecs[6]  = '{1'b0, 1'b0, 10,  1'b0, 1'b0, 1'b1, 0, 1, 0, 0};
      vecs[7]  = '{1'b1, 1'b0, 10,  1'b1, 1'b0, 1'b1, 1, 0, 0, 0};
      vecs[8]  = '{1'b1, 1'b1, 10,  1'b1, 1'b1, 1'b0, 0, 0, 0, 1};
      vecs[9]  = '{1'b0, 1'b0, 10,  1'b0, 1'b0, 1'b0, 0, 1, 0, 0};
      vecs[10] = '{1'b1, 1'b1, 10,  1'b1, 1'b1, 1'b0, 1, 0, 0, 0};
      vecs[11] = '{1'b0, 1'b1, 10,  1'b0, 1'b1, 1'b0, 0, 1, 0, 0};
      vecs[12] = '{1'b0, 1'b0, 10,  1'b0, 1'b0, 1'b0, 0, 0, 0, 0};
      vecs[13] = '{1'b1, 1'b0, 10,  1'b1, 1'b0, 1'b0, 1, 0, 0, 0};
      vecs[14] = '{1'b1, 1'b1, 10,  1'b1, 1'b1, 1'b0, 0, 0, 0, 1};

      rst_n = 1'b0;
      scl   = 1'b1;
      sda   = 1'b1;
      step(3);
      chk("reset_scl_o", int'(scl_o), 1);
      chk("reset_sda_o", int'(sda_o), 1);
      chk("reset_busy_o", int'(busy_o), 0);
      chk("reset_strobes", int'({scl_rise_o, scl_fall_o, start_o, stop_o, timeout_o}), 0);
      rst_n = 1'b1;
      step(10);

      // START latency: SYNC_STAGES + FILTER_CYCLES = 5, busy one cycle later
      sda = 1'b0;
      for (int i = 1; i <= 6; i++) begin
         step(1);
         chk($sformatf("start_lat c%0d start_o", i), int'(start_o), (i == 5) ? 1 : 0);
         chk($sformatf("start_lat c%0d sda_o", i), int'(sda_o), (i < 5) ? 1 : 0);
         chk($sformatf("start_lat c%0d busy_o", i), int'(busy_o), (i >= 6) ? 1 : 0);
      end
      step(4);
      sda = 1'b1;
      for (int i = 1; i <= 6; i++) begin
         step(1);
         chk($sformatf("stop_lat c%0d stop_o", i), int'(stop_o), (i == 5) ? 1 : 0);
         chk($sformatf("stop_lat c%0d busy_o", i), int'(busy_o), (i < 6) ? 1 : 0);
      end
      step(4);

      // 2-cycle glitch is rejected
      b_start = n_start;
      b_stop  = n_stop;
      sda = 1'b0;
      low_cycles = 0;
      for (int i = 0; i < 2; i++) begin
         step(1);
         low_cycles += int'(!sda_o);
      end
      sda = 1'b1;
      for (int i = 0; i < 12; i++) begin
         step(1);
         low_cycles += int'(!sda_o);
      end
      chk("glitch2 sda_o low cycles", low_cycles, 0);
      chk("glitch2 start count", n_start - b_start, 0);
      chk("glitch2 stop count", n_stop - b_stop, 0);

      // 3-cycle pulse passes: one START then one STOP
      sda = 1'b0;
      step(3);
      sda = 1'b1;
      step(12);
      chk("pulse3 start count", n_start - b_start, 1);
      chk("pulse3 stop count", n_stop - b_stop, 1);
      chk("pulse3 busy_o", int'(busy_o), 0);

      foreach (vecs[v]) begin
         b_rise  = n_rise;
         b_fall  = n_fall;
         b_start = n_start;
         b_stop  = n_stop;
         scl = vecs[v].scl;
         sda = vecs[v].sda;
         step(vecs[v].hold);
         chk($sformatf("vec%0d scl_o", v), int'(scl_o), int'(vecs[v].exp_scl));
         chk($sformatf("vec%0d sda_o", v), int'(sda_o), int'(vecs[v].exp_sda));
         chk($sformatf("vec%0d busy_o", v), int'(busy_o), int'(vecs[v].exp_busy));
         chk($sformatf("vec%0d rise", v), n_rise - b_rise, vecs[v].d_rise);
         chk($sformatf("vec%0d fall", v), n_fall - b_fall, vecs[v].d_fall);
         chk($sformatf("vec%0d start", v), n_start - b_start, vecs[v].d_start);
         chk($sformatf("vec%0d stop", v), n_stop - b_stop, vecs[v].d_stop);
      end

      // full byte + ACK: 9 SCL pulses, SDA changing only while SCL low
      pattern = 9'b1_0110_1001;
      sda = 1'b0;
      step(10);
      b_rise  = n_rise;
      b_fall  = n_fall;
      b_start = n_start;
      b_stop  = n_stop;
      for (int i = 0; i < 9; i++) begin
         scl = 1'b0;
         step(3);
         sda = pattern[i];
         step(7);
         scl = 1'b1;
         step(10);
      end
      chk("byte rise count", n_rise - b_rise, 9);
      chk("byte fall count", n_fall - b_fall, 9);
      chk("byte start count", n_start - b_start, 0);
      chk("byte stop count", n_stop - b_stop, 0);
      chk("byte busy_o", int'(busy_o), 1);
      scl = 1'b0;
      step(10);
      sda = 1'b0;
      step(10);
      scl = 1'b1;
      step(10);
      sda = 1'b1;
      step(10);
      chk("byte end busy_o", int'(busy_o), 0);

      // asynchronous reset mid-byte
      sda = 1'b0;
      step(10);
      scl = 1'b0;
      step(10);
      sda = 1'b1;
      step(3);
      chk("pre_reset busy_o", int'(busy_o), 1);
      chk("pre_reset scl_o", int'(scl_o), 0);
      #3 rst_n = 1'b0;
      #1;
      chk("async_reset scl_o", int'(scl_o), 1);
      chk("async_reset sda_o", int'(sda_o), 1);
      chk("async_reset busy_o", int'(busy_o), 0);
      step(3);
      rst_n = 1'b1;
      step(1);
      chk("post_release strobes", int'({scl_rise_o, scl_fall_o, start_o, stop_o, timeout_o}), 0);
      chk("post_release scl_o", int'(scl_o), 1);
      b_start = n_start;
      scl = 1'b1;
      step(15);
      chk("post_release start count", n_start - b_start, 0);
      chk("post_release busy_o", int'(busy_o), 0);

`ifdef I2C_TIMEOUT_EN
      b_to = n_to;
      sda = 1'b0;
      step(10);
      scl = 1'b0;
      k = 0;
      while (scl_o && k < 20) begin
         step(1);
         k++;
      end
      chk("timeout scl_o fell", int'(scl_o), 0);
      k = 0;
      while (!timeout_o && k < 100) begin
         step(1);
         k++;
      end
      chk("timeout latency", k, 50);
      chk("timeout busy_o", int'(busy_o), 0);
      step(60);
      chk("timeout pulse count", n_to - b_to, 1);
      scl = 1'b1;
      step(10);
      sda = 1'b1;
      step(10);
`else
      b_to = n_to;
      sda = 1'b0;
      step(10);
      scl = 1'b0;
      step(80);
      chk("no_timeout busy_o", int'(busy_o), 1);
      chk("timeout_o count", n_to - b_to, 0);
      scl = 1'b1;
      step(10);
      sda = 1'b1;
      step(10);
      chk("no_timeout final busy_o", int'(busy_o), 0);
`endif

      chk("back_to_back strobes", n_consec, 0);
      chk("total timeout pulses", n_to,
`ifdef I2C_TIMEOUT_EN
          1
`else
          0
`endif
      );

      $display("%0d/%0d checks passed", n_pass, n_checks);
      $finish;
   end

endmodule
